fp_result_pack: RTL and testbench

- Consumer end of the FPMul auxiliary flag bus: takes the multiplier's prepared sign/exponent/mantissa plus the 12-bit flag bus and produces the final IEEE-754 single-precision product.
- Decodes flag classes and applies the round increment, including mantissa carry into the exponent.
- Selects special encodings (NaN, infinity, zero) and accumulates sticky exception status.
- 2-stage valid/ready pipeline sitting between the multiplier datapath/flag generator and the result writeback.

---
 rtl/fp_result_pack.sv | 226 ++++++++++++++++++++++
 tb/tb_fp_result_pack.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fp_result_pack.sv
// -----------------------------------------------------------------------------
// fp_result_pack
//   Consumer end of the FPMul auxiliary flag bus. Takes the multiplier's
//   prepared sign/exponent/mantissa plus the 12-bit flag bus, classifies the
//   bundle, applies the round increment (with mantissa carry into the
//   exponent), selects special encodings and produces the final IEEE-754
//   single-precision product through a 2-stage valid/ready pipeline.
//
//   Stage 1 : registers sign/exp/mant, priority-encoded class, round, carry.
//   Stage 2 : registers packed result and per-result exceptions.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   in_valid     operand/flag bundle valid
//   in_ready     bundle accepted when in_valid & in_ready (combinational
//                from out_ready)
//   in_sign      product sign
//   in_exp       prepared biased exponent (only [7:0] used for results)
//   in_mant      prepared fraction, unrounded
//   in_flags     flag bus {AP_ZF, AP_DNF, AP_INFF, AP_NANF, MAP_HF, round,
//                underflow, overflow, AB_NAN, AB_INF, AB_ZERO, AB_DNF}
//   out_valid    result valid
//   out_ready    downstream accepts the result
//   out_result   packed IEEE-754 result
//   out_exc      {invalid, overflow, underflow, inexact, denormal}
//   status       sticky OR of out_exc over transferred results
//   clr_status   synchronous clear of status
//
// Build option
//   FPRES_DENORM_PASS_EN : when defined, denormal-class bundles are passed
//   through as {sign, 8'h00, rounded mantissa} instead of flushed to zero.
// -----------------------------------------------------------------------------
module fp_result_pack #(
   parameter logic [31:0] QNAN  = 32'h7FC0_0000,
   parameter int          EXP_W = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sign,
   input  logic [EXP_W-1:0] in_exp,
   input  logic [22:0]      in_mant,
   input  logic [11:0]      in_flags,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_result,
   output logic [4:0]       out_exc,
   output logic [4:0]       status,
   input  logic             clr_status
);

   // One-hot result class, ordered by priority.
   typedef enum logic [6:0] {
      CLS_NORM = 7'b000_0001,
      CLS_OFL  = 7'b000_0010,
      CLS_UFL  = 7'b000_0100,
      CLS_DNF  = 7'b000_1000,
      CLS_ZERO = 7'b001_0000,
      CLS_INF  = 7'b010_0000,
      CLS_NAN  = 7'b100_0000
   } cls_e;

   localparam int EXC_INV = 4;
   localparam int EXC_OFL = 3;
   localparam int EXC_UFL = 2;
   localparam int EXC_INX = 1;
   localparam int EXC_DNF = 0;

   // Exponent bits above [7:0] carry no information for the packed result.
   logic unused_exp_hi;
   assign unused_exp_hi = ^in_exp[EXP_W-1:8];

   // Stage 1 state
   logic        s1_valid_q, s1_valid_d;
   logic        s1_sign_q,  s1_sign_d;
   logic [7:0]  s1_exp_q,   s1_exp_d;
   logic [22:0] s1_mant_q,  s1_mant_d;
   logic        s1_round_q, s1_round_d;
   logic        s1_carry_q, s1_carry_d;
   cls_e        s1_cls_q,   s1_cls_d;

   // Stage 2 state
   logic        out_valid_q,  out_valid_d;
   logic [31:0] out_result_q, out_result_d;
   logic [4:0]  out_exc_q,    out_exc_d;
   logic [4:0]  status_q,     status_d;

   logic        s1_en, s2_en;
   logic [22:0] mant_r;
   logic [8:0]  exp_r;
   logic [31:0] res;
   logic [4:0]  exc;

   assign s2_en    = ~out_valid_q | out_ready;
   assign s1_en    = ~s1_valid_q | s2_en;
   assign in_ready = s1_en;

   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      s1_valid_d = s1_valid_q;
      s1_sign_d  = s1_sign_q;
      s1_exp_d   = s1_exp_q;
      s1_mant_d  = s1_mant_q;
      s1_round_d = s1_round_q;
      s1_carry_d = s1_carry_q;
      s1_cls_d   = s1_cls_q;

      if (s1_en) begin
         s1_valid_d = in_valid;
         s1_sign_d  = in_sign;
         s1_exp_d   = in_exp[7:0];
         s1_mant_d  = in_mant;
         s1_round_d = in_flags[6];
         s1_carry_d = in_flags[6] & in_flags[7];
         if (in_flags[8] | in_flags[3])       s1_cls_d = CLS_NAN;
         else if (in_flags[9] | in_flags[2])  s1_cls_d = CLS_INF;
         else if (in_flags[11] | in_flags[1]) s1_cls_d = CLS_ZERO;
         else if (in_flags[10] | in_flags[0]) s1_cls_d = CLS_DNF;
         else if (in_flags[5])                s1_cls_d = CLS_UFL;
         else if (in_flags[4])                s1_cls_d = CLS_OFL;
         else                                 s1_cls_d = CLS_NORM;
      end
   end

   // Stage 2 packing. The round increment wraps the 23-bit fraction; the
   // wrap is paired with the carry into the exponent (round & MAP_HF).
   always_comb begin
      mant_r = s1_mant_q + {22'b0, s1_round_q};
      exp_r  = {1'b0, s1_exp_q} + {8'b0, s1_carry_q};
      res    = '0;
      exc    = '0;
      case (s1_cls_q)
         CLS_NAN: begin
            res          = QNAN;
            exc[EXC_INV] = 1'b1;
         end
         CLS_INF: res = {s1_sign_q, 8'hFF, 23'b0};
         CLS_ZERO: res = {s1_sign_q, 31'b0};
         CLS_DNF: begin
`ifdef FPRES_DENORM_PASS_EN
            res          = {s1_sign_q, 8'h00, mant_r};
            exc[EXC_DNF] = 1'b1;
            exc[EXC_UFL] = s1_round_q;
`else
            res          = {s1_sign_q, 31'b0};
            exc[EXC_DNF] = 1'b1;
            exc[EXC_UFL] = 1'b1;
`endif
         end
         CLS_UFL: begin
            res          = {s1_sign_q, 31'b0};
            exc[EXC_UFL] = 1'b1;
            exc[EXC_INX] = 1'b1;
         end
         CLS_OFL: begin
            res          = {s1_sign_q, 8'hFF, 23'b0};
            exc[EXC_OFL] = 1'b1;
            exc[EXC_INX] = 1'b1;
         end
         default: begin
            exc[EXC_INX] = s1_round_q;
            // Biased exponent 255 is reserved, so a rounded exponent that
            // reaches it becomes infinity.
            if (exp_r >= 9'd255) begin
               res          = {s1_sign_q, 8'hFF, 23'b0};
               exc[EXC_OFL] = 1'b1;
            end else begin
               res = {s1_sign_q, exp_r[7:0], mant_r};
            end
         end
      endcase
   end

   always_comb begin
      out_valid_d  = out_valid_q;
      out_result_d = out_result_q;
      out_exc_d    = out_exc_q;
      if (s2_en) begin
         out_valid_d  = s1_valid_q;
         out_result_d = s1_valid_q ? res : 32'b0;
         out_exc_d    = s1_valid_q ? exc : 5'b0;
      end
      // Clear applies first so a same-cycle transfer survives it.
      status_d = (clr_status ? 5'b0 : status_q)
               | ((out_valid_q & out_ready) ? out_exc_q : 5'b0);
   end

   // NOTE: all pipeline state, data included, is reset so nothing stale can
   // surface after a mid-operation reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid_q   <= 1'b0;
         s1_sign_q    <= 1'b0;
         s1_exp_q     <= '0;
         s1_mant_q    <= '0;
         s1_round_q   <= 1'b0;
         s1_carry_q   <= 1'b0;
         s1_cls_q     <= CLS_NORM;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_exc_q    <= '0;
         status_q     <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         s1_valid_q   <= s1_valid_d;
         s1_sign_q    <= s1_sign_d;
         s1_exp_q     <= s1_exp_d;
         s1_mant_q    <= s1_mant_d;
         s1_round_q   <= s1_round_d;
         s1_carry_q   <= s1_carry_d;
         s1_cls_q     <= s1_cls_d;
         out_valid_q  <= out_valid_d;
         out_result_q <= out_result_d;
         out_exc_q    <= out_exc_d;
         status_q     <= status_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;
   assign out_exc    = out_exc_q;
   assign status     = status_q;

endmodule

// File: tb/tb_fp_result_pack.sv
// -----------------------------------------------------------------------------
// tb_fp_result_pack
//   Directed self-checking bench for fp_result_pack: reset state, normal and
//   rounded products, special classes, backpressure ordering, sticky status
//   with clear, and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_fp_result_pack;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [9:0]  in_exp;
   logic [22:0] in_mant;
   logic [11:0] in_flags;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_exc;
   logic [4:0]  status;
   logic        clr_status;

   int n_checks = 0;
   int n_errors = 0;
   logic [4:0] status_m = 5'b0;

   fp_result_pack dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sign    (in_sign),
      .in_exp     (in_exp),
      .in_mant    (in_mant),
      .in_flags   (in_flags),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_exc    (out_exc),
      .status     (status),
      .clr_status (clr_status)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Sends one bundle into an empty pipeline, checks the 2-cycle latency,
   // the result and exceptions, then the status after the transfer.
   task automatic run_one(input string tag, input logic s, input logic [9:0] e,
                          input logic [22:0] m, input logic [11:0] f, input logic clr,
                          input logic [31:0] er, input logic [4:0] ee);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_sign   = s;
      in_exp    = e;
      in_mant   = m;
      in_flags  = f;
      step();
      in_valid = 1'b0;
      check({tag, "_lat1"}, out_valid, 1'b0);
      step();
      check({tag, "_valid"}, out_valid, 1'b1);
      check({tag, "_res"}, out_result, er);
      check({tag, "_exc"}, out_exc, ee);
      clr_status = clr;
      step();
      clr_status = 1'b0;
      status_m   = (clr ? 5'b0 : status_m) | ee;
      check({tag, "_status"}, status, status_m);
   endtask

   initial begin
      int idx;
      int n_out;
      logic seen;
      logic [31:0] bp_exp;

      rst        = 1'b0;
      in_valid   = 1'b0;
      in_sign    = 1'b0;
      in_exp     = '0;
      in_mant    = '0;
      in_flags   = '0;
      out_ready  = 1'b0;
      clr_status = 1'b0;
      step();
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_result", out_result, 32'h0);
      check("rst_out_exc", out_exc, 5'b0);
      check("rst_status", status, 5'b0);
      rst = 1'b1;
      step();

      run_one("normal",   1'b0, 10'h07F, 23'h000000, 12'h000, 1'b0, 32'h3F80_0000, 5'b00000);
      run_one("rnd_ovf",  1'b1, 10'h0FE, 23'h7FFFFF, 12'h0C0, 1'b0, 32'hFF80_0000, 5'b01010);
      run_one("nan",      1'b0, 10'h000, 23'h000000, 12'h00C, 1'b0, 32'h7FC0_0000, 5'b10000);
      run_one("zero",     1'b1, 10'h000, 23'h000000, 12'h002, 1'b0, 32'h8000_0000, 5'b00000);
      run_one("rnd",      1'b0, 10'h080, 23'h000001, 12'h040, 1'b0, 32'h4000_0002, 5'b00010);
      run_one("rnd_cry",  1'b0, 10'h07F, 23'h7FFFFF, 12'h0C0, 1'b0, 32'h4000_0000, 5'b00010);
      run_one("inf",      1'b0, 10'h000, 23'h000000, 12'h004, 1'b0, 32'h7F80_0000, 5'b00000);
`ifdef FPRES_DENORM_PASS_EN
      run_one("dnf",      1'b1, 10'h000, 23'h000005, 12'h001, 1'b0, 32'h8000_0005, 5'b00001);
`else
      run_one("dnf",      1'b1, 10'h000, 23'h000005, 12'h001, 1'b0, 32'h8000_0000, 5'b00101);
`endif
      run_one("ufl_ofl",  1'b0, 10'h000, 23'h000000, 12'h030, 1'b0, 32'h0000_0000, 5'b00110);
      run_one("ofl",      1'b1, 10'h000, 23'h000000, 12'h010, 1'b0, 32'hFF80_0000, 5'b01010);
      run_one("exp_ff",   1'b0, 10'h0FF, 23'h000000, 12'h000, 1'b0, 32'h7F80_0000, 5'b01000);
      run_one("exp_hi",   1'b0, 10'h17F, 23'h000000, 12'h000, 1'b0, 32'h3F80_0000, 5'b00000);

      // Clear together with a transferring UFL result keeps only the new bits.
      run_one("clr_ufl",  1'b0, 10'h000, 23'h000000, 12'h020, 1'b1, 32'h0000_0000, 5'b00110);
      check("clr_ufl_exact", status, 5'b00110);
      clr_status = 1'b1;
      step();
      clr_status = 1'b0;
      status_m   = 5'b0;
      check("clr_alone", status, 5'b0);

      // Backpressure: 4 back-to-back bundles, out_ready low for 3 cycles.
      idx   = 0;
      n_out = 0;
      for (int c = 0; c < 20; c++) begin
         out_ready = (c >= 3);
         in_valid  = (idx < 4);
         in_sign   = 1'b0;
         in_exp    = 10'h080 + 10'(idx);
         in_mant   = 23'(idx + 1);
         in_flags  = 12'h000;
         @(negedge clk);
         if (c == 2) begin
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_accepts", idx, 2);
         end
         if (out_valid && out_ready) begin
            bp_exp = {1'b0, 8'h80 + 8'(n_out), 23'(n_out + 1)};
            if (n_out < 4) check($sformatf("bp_order%0d", n_out), out_result, bp_exp);
            n_out++;
         end
         if (in_valid && in_ready) idx++;
         step();
      end
      in_valid = 1'b0;
      check("bp_sent", idx, 4);
      check("bp_count", n_out, 4);

      // Mid-operation reset with two bundles in flight and status set.
      run_one("pre_rst",  1'b0, 10'h000, 23'h000000, 12'h010, 1'b0, 32'h7F80_0000, 5'b01010);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_exp    = 10'h07F;
      in_mant   = 23'h0;
      in_flags  = 12'h000;
      step();
      step();
      in_valid = 1'b0;
      check("inflight_valid", out_valid, 1'b1);
      rst = 1'b0;
      #1;
      check("arst_out_valid", out_valid, 1'b0);
      check("arst_status", status, 5'b0);
      check("arst_out_exc", out_exc, 5'b0);
      check("arst_in_ready", in_ready, 1'b1);
      #2;
      rst       = 1'b1;
      out_ready = 1'b1;
      seen      = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check("arst_no_result", seen, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
